ecc_point_seq: RTL and testbench

//  Sequences ECC_core (field ADD/SUB/MULT/INV) to compute one affine point operation R=P+Q or R=2P
//  on y^2=x^3+a*x+b mod prime. Holds operands and temporaries (t0, t1, lam) internally.

---
 rtl/ecc_point_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_ecc_point_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_point_seq.sv
// Affine point add/double sequencer: walks a fixed field-op program over a shared
// ADD/SUB/MULT/INV core, resolving infinity and P==-Q cases up front with no core traffic.
module ecc_point_seq #(
  parameter int W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         start,
  input  logic         mode,
  input  logic         p_inf,
  input  logic         q_inf,
  input  logic [W-1:0] px,
  input  logic [W-1:0] py,
  input  logic [W-1:0] qx,
  input  logic [W-1:0] qy,
  input  logic [W-1:0] curve_a,
  input  logic [W-1:0] prime,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rx,
  output logic [W-1:0] ry,
  output logic         r_inf,
  output logic         alu_start,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [W-1:0] alu_prime,
  output logic [2:0]   alu_sel,
  input  logic [W-1:0] alu_result,
  input  logic         alu_done
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_GAP, S_FIN} state_t;
  typedef enum logic [3:0] {SRC_PX, SRC_PY, SRC_QX, SRC_QY, SRC_A, SRC_T0, SRC_T1,
                            SRC_LAM, SRC_X3, SRC_X2, SRC_ONE} src_t;
  typedef enum logic [2:0] {D_T0, D_T1, D_LAM, D_X3, D_Y3} dst_t;
  typedef struct packed {
    logic [2:0] sel;
    src_t       a;
    src_t       b;
    dst_t       d;
  } op_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_INV = 3'b100;

  function automatic op_t mk(input logic [2:0] sel, input src_t a, input src_t b, input dst_t d);
    op_t o;
    o.sel = sel;
    o.a   = a;
    o.b   = b;
    o.d   = d;
    return o;
  endfunction

  // Shared tail: x3 = lam^2 - px - x2, y3 = lam*(px - x3) - py
  function automatic op_t tail_op(input logic [3:0] i);
    case (i)
      4'd0:    return mk(OP_MUL, SRC_LAM, SRC_LAM, D_T0);
      4'd1:    return mk(OP_SUB, SRC_T0,  SRC_PX,  D_T0);
      4'd2:    return mk(OP_SUB, SRC_T0,  SRC_X2,  D_X3);
      4'd3:    return mk(OP_SUB, SRC_PX,  SRC_X3,  D_T0);
      4'd4:    return mk(OP_MUL, SRC_LAM, SRC_T0,  D_T0);
      4'd5:    return mk(OP_SUB, SRC_T0,  SRC_PY,  D_Y3);
      default: return mk(3'b000, SRC_ONE, SRC_ONE, D_T0);
    endcase
  endfunction

  function automatic op_t prog_op(input logic [3:0] s, input logic dbl);
    if (dbl) begin
      case (s)
        4'd0:    return mk(OP_MUL, SRC_PX,  SRC_PX, D_T0);
        4'd1:    return mk(OP_ADD, SRC_T0,  SRC_T0, D_T1);
        4'd2:    return mk(OP_ADD, SRC_T1,  SRC_T0, D_T0);
        4'd3:    return mk(OP_ADD, SRC_T0,  SRC_A,  D_T0);
        4'd4:    return mk(OP_ADD, SRC_PY,  SRC_PY, D_T1);
        4'd5:    return mk(OP_INV, SRC_ONE, SRC_T1, D_T1);
        4'd6:    return mk(OP_MUL, SRC_T0,  SRC_T1, D_LAM);
        default: return tail_op(s - 4'd7);
      endcase
    end else begin
      case (s)
        4'd0:    return mk(OP_SUB, SRC_QY,  SRC_PY, D_T0);
        4'd1:    return mk(OP_SUB, SRC_QX,  SRC_PX, D_T1);
        4'd2:    return mk(OP_INV, SRC_ONE, SRC_T1, D_T1);
        4'd3:    return mk(OP_MUL, SRC_T0,  SRC_T1, D_LAM);
        default: return tail_op(s - 4'd4);
      endcase
    end
  endfunction

  state_t       state_reg;
  logic         mode_reg, p_inf_reg, q_inf_reg, dbl_reg;
  logic [W-1:0] px_reg, py_reg, qx_reg, qy_reg, a_reg;
  logic [W-1:0] t0_reg, t1_reg, lam_reg, x3_reg, y3_reg;
  logic [3:0]   step_reg;
  dst_t         dst_reg;

  logic         eq_x, eq_y, dbl_next;
  logic [3:0]   step_next, n_ops;
  op_t          cur_op;
  logic [W-1:0] src_bank [0:15];
  logic [W-1:0] op_a_val, op_b_val;

  // Operands for the op about to be issued: step 0 out of CHECK, step+1 out of GAP
  always_comb begin
    eq_x      = (px_reg == qx_reg);
    eq_y      = (py_reg == qy_reg);
    dbl_next  = (state_reg == S_CHECK) ? (mode_reg | eq_x) : dbl_reg;
    step_next = (state_reg == S_GAP) ? step_reg + 4'd1 : 4'd0;
    n_ops     = dbl_reg ? 4'd13 : 4'd10;
    cur_op    = prog_op(step_next, dbl_next);
    for (int i = 0; i < 16; i++) src_bank[i] = '0;
    src_bank[SRC_PX]  = px_reg;
    src_bank[SRC_PY]  = py_reg;
    src_bank[SRC_QX]  = qx_reg;
    src_bank[SRC_QY]  = qy_reg;
    src_bank[SRC_A]   = a_reg;
    src_bank[SRC_T0]  = t0_reg;
    src_bank[SRC_T1]  = t1_reg;
    src_bank[SRC_LAM] = lam_reg;
    src_bank[SRC_X3]  = x3_reg;
    src_bank[SRC_X2]  = dbl_reg ? px_reg : qx_reg;
    src_bank[SRC_ONE] = W'(1);
    op_a_val = src_bank[cur_op.a];
    op_b_val = src_bank[cur_op.b];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      r_inf     <= 1'b0;
      rx        <= '0;
      ry        <= '0;
      alu_start <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_prime <= '0;
      alu_sel   <= 3'b000;
      mode_reg  <= 1'b0;
      p_inf_reg <= 1'b0;
      q_inf_reg <= 1'b0;
      dbl_reg   <= 1'b0;
      px_reg    <= '0;
      py_reg    <= '0;
      qx_reg    <= '0;
      qy_reg    <= '0;
      a_reg     <= '0;
      t0_reg    <= '0;
      t1_reg    <= '0;
      lam_reg   <= '0;
      x3_reg    <= '0;
      y3_reg    <= '0;
      step_reg  <= '0;
      dst_reg   <= D_T0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          mode_reg  <= mode;
          p_inf_reg <= p_inf;
          q_inf_reg <= q_inf;
          dbl_reg   <= mode;
          px_reg    <= px;
          py_reg    <= py;
          qx_reg    <= qx;
          qy_reg    <= qy;
          a_reg     <= curve_a;
          alu_prime <= prime;
          busy      <= 1'b1;
          state_reg <= S_CHECK;
        end
        S_CHECK: begin
          if (!mode_reg && p_inf_reg) begin
            rx        <= q_inf_reg ? '0 : qx_reg;
            ry        <= q_inf_reg ? '0 : qy_reg;
            r_inf     <= q_inf_reg;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= S_FIN;
          end else if (!mode_reg && q_inf_reg) begin
            rx        <= px_reg;
            ry        <= py_reg;
            r_inf     <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= S_FIN;
          end else if (mode_reg ? (p_inf_reg || py_reg == '0) : (eq_x && !eq_y)) begin
            rx        <= '0;
            ry        <= '0;
            r_inf     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= S_FIN;
          end else begin
            dbl_reg   <= dbl_next;
            step_reg  <= 4'd0;
            alu_a     <= op_a_val;
            alu_b     <= op_b_val;
            alu_sel   <= cur_op.sel;
            dst_reg   <= cur_op.d;
            alu_start <= 1'b1;
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: state_reg <= S_WAIT;
        S_WAIT: if (alu_done) begin
          case (dst_reg)
            D_T0:    t0_reg  <= alu_result;
            D_T1:    t1_reg  <= alu_result;
            D_LAM:   lam_reg <= alu_result;
            D_X3:    x3_reg  <= alu_result;
            D_Y3:    y3_reg  <= alu_result;
            default: ;
          endcase
          alu_start <= 1'b0;
          state_reg <= S_GAP;
        end
        S_GAP: begin
          if (step_next == n_ops) begin
            rx        <= x3_reg;
            ry        <= y3_reg;
            r_inf     <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= S_FIN;
          end else begin
            step_reg  <= step_next;
            alu_a     <= op_a_val;
            alu_b     <= op_b_val;
            alu_sel   <= cur_op.sel;
            dst_reg   <= cur_op.d;
            alu_start <= 1'b1;
            state_reg <= S_ISSUE;
          end
        end
        S_FIN: begin
          done      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_point_seq.sv
// Bench for ecc_point_seq: behavioural field core with random latency, vector table
// of point operations, and a done-driven scoreboard checking R, op count and latency.
module tb_ecc_point_seq;

  localparam int W = 256;

  logic         clk, rst;
  logic         start, mode, p_inf, q_inf;
  logic [W-1:0] px, py, qx, qy, curve_a, prime;
  logic         busy, done, r_inf, alu_start, alu_done;
  logic [W-1:0] rx, ry, alu_a, alu_b, alu_prime, alu_result;
  logic [2:0]   alu_sel;

  ecc_point_seq #(.W(W)) dut (
    .i_clk(clk), .i_rst(rst), .start(start), .mode(mode), .p_inf(p_inf), .q_inf(q_inf),
    .px(px), .py(py), .qx(qx), .qy(qy), .curve_a(curve_a), .prime(prime),
    .busy(busy), .done(done), .rx(rx), .ry(ry), .r_inf(r_inf),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_prime(alu_prime),
    .alu_sel(alu_sel), .alu_result(alu_result), .alu_done(alu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural field core ----------------
  function automatic logic [W-1:0] f_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] p);
    logic [2*W-1:0] t;
    t = (2*W)'(a) * (2*W)'(b);
    t = t % (2*W)'(p);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] f_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] p);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] f_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] p);
    logic [W:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + {1'b0, p} - {1'b0, b};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] f_inv(input logic [W-1:0] b, input logic [W-1:0] p);
    logic [W-1:0] e, r, base;
    e = p - W'(2);
    r = W'(1);
    base = b;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = f_mul(r, base, p);
      base = f_mul(base, base, p);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] f_alu(input logic [2:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] p);
    case (s)
      3'b001:  return f_add(a, b, p);
      3'b010:  return f_sub(a, b, p);
      3'b011:  return f_mul(a, b, p);
      3'b100:  return f_mul(a, f_inv(b, p), p);
      default: return '0;
    endcase
  endfunction

  initial begin
    int cnt;
    bit pending;
    alu_done = 1'b0;
    alu_result = '0;
    pending = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !alu_start) begin
        alu_done = 1'b0;
        pending = 1'b0;
      end else if (!alu_done) begin
        if (!pending) begin
          pending = 1'b1;
          cnt = $urandom_range(0, 19);
        end
        if (cnt == 0) begin
          alu_result = f_alu(alu_sel, alu_a, alu_b, alu_prime);
          alu_done = 1'b1;
        end else begin
          cnt--;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         inf;
    int           ops;
  } exp_t;
  exp_t exp_q[$];

  initial begin
    bit           prev_start, prev_busy, prev_done;
    int           t0, hcnt, ops, low_run, txn;
    logic [W-1:0] pa, pb;
    logic [2:0]   psel;
    exp_t         e;
    prev_start = 0; prev_busy = 0; prev_done = 0;
    t0 = 0; hcnt = 0; ops = 0; low_run = 0; txn = 0;
    pa = '0; pb = '0; psel = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 0; prev_busy = 0; prev_done = 0;
      end else begin
        if (busy && !prev_busy) begin
          t0 = cyc; hcnt = 0; ops = 0; low_run = 0;
        end
        if (alu_start) begin
          if (!prev_start) begin
            if (ops > 0) chk("gap_len", W'(low_run), W'(1));
            ops++;
          end else begin
            chk("held_operands", {alu_a, alu_b, alu_sel} == {pa, pb, psel}, W'(1));
          end
          hcnt++;
          low_run = 0;
          pa = alu_a; pb = alu_b; psel = alu_sel;
        end else begin
          low_run++;
        end
        if (done) begin
          chk("single_done_pulse", W'(prev_done), W'(0));
          chk("busy_low_at_done", W'(busy), W'(0));
          if (exp_q.size() == 0) begin
            chk("unexpected_done", W'(1), W'(0));
          end else begin
            e = exp_q.pop_front();
            chk("rx", rx, e.rx);
            chk("ry", ry, e.ry);
            chk("r_inf", W'(r_inf), W'(e.inf));
            chk("alu_op_count", W'(ops), W'(e.ops));
            chk("latency", W'(cyc - t0 + 1), W'(2 + hcnt + ops));
          end
          $display("txn %0d: rx=%h ry=%h r_inf=%0d ops=%0d latency=%0d",
                   txn, rx, ry, r_inf, ops, cyc - t0 + 1);
          txn++;
        end
        prev_start = alu_start; prev_busy = busy; prev_done = done;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic         mode, p_inf, q_inf, hold;
    logic [W-1:0] px, py, qx, qy, a, p;
    logic [W-1:0] erx, ery;
    logic         einf;
    int           eops;
  } vec_t;

  localparam logic [W-1:0] SP  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [W-1:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [W-1:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [W-1:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [W-1:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

  function automatic vec_t mkv(input logic m, input logic pi, input logic qi, input logic h,
                               input logic [W-1:0] x1, input logic [W-1:0] y1,
                               input logic [W-1:0] x2, input logic [W-1:0] y2,
                               input logic [W-1:0] a, input logic [W-1:0] p,
                               input logic [W-1:0] ex, input logic [W-1:0] ey,
                               input logic ei, input int eo);
    vec_t v;
    v.mode = m; v.p_inf = pi; v.q_inf = qi; v.hold = h;
    v.px = x1; v.py = y1; v.qx = x2; v.qy = y2; v.a = a; v.p = p;
    v.erx = ex; v.ery = ey; v.einf = ei; v.eops = eo;
    return v;
  endfunction

  task automatic apply_inputs(input vec_t v);
    mode = v.mode; p_inf = v.p_inf; q_inf = v.q_inf;
    px = v.px; py = v.py; qx = v.qx; qy = v.qy; curve_a = v.a; prime = v.p;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    int   k;
    @(negedge clk);
    apply_inputs(v);
    e.rx = v.erx; e.ry = v.ery; e.inf = v.einf; e.ops = v.eops;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    if (v.hold) repeat (6) @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 3000; k++) begin
      if (done) break;
      @(negedge clk);
    end
    if (k == 3000) begin
      failures++;
      $display("FAIL %s: no done within 3000 cycles", name);
      exp_q.delete();
    end
  endtask

  vec_t vecs[11];

  initial begin
    int   n, k, bad;
    bit   ps;
    rst = 1'b1; start = 1'b0;
    mode = 0; p_inf = 0; q_inf = 0;
    px = '0; py = '0; qx = '0; qy = '0; curve_a = '0; prime = '0;

    vecs[0]  = mkv(1, 0, 0, 0, 5, 1, 0, 0, 2, 17, 6, 3, 0, 13);
    vecs[1]  = mkv(0, 0, 0, 1, 5, 1, 6, 3, 2, 17, 10, 6, 0, 10);
    vecs[2]  = mkv(0, 0, 0, 0, 5, 1, 5, 1, 2, 17, 6, 3, 0, 13);
    vecs[3]  = mkv(0, 0, 0, 0, 5, 1, 5, 16, 2, 17, 0, 0, 1, 0);
    vecs[4]  = mkv(0, 1, 0, 0, 9, 9, 6, 3, 2, 17, 6, 3, 0, 0);
    vecs[5]  = mkv(0, 0, 1, 0, 10, 6, 4, 4, 2, 17, 10, 6, 0, 0);
    vecs[6]  = mkv(0, 1, 1, 0, 5, 1, 6, 3, 2, 17, 0, 0, 1, 0);
    vecs[7]  = mkv(1, 1, 0, 0, 5, 1, 6, 3, 2, 17, 0, 0, 1, 0);
    vecs[8]  = mkv(1, 0, 0, 0, 3, 0, 6, 3, 2, 17, 0, 0, 1, 0);
    vecs[9]  = mkv(0, 0, 0, 0, 5, 1, 10, 6, 2, 17, 3, 1, 0, 10);
    vecs[10] = mkv(1, 0, 0, 0, GX, GY, 0, 0, 0, SP, G2X, G2Y, 0, 13);

    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_alu_start", W'(alu_start), W'(0));
    chk("rst_r_inf", W'(r_inf), W'(0));
    chk("rst_rx", rx, '0);
    chk("rst_ry", ry, '0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_b", alu_b, '0);
    chk("rst_alu_prime", alu_prime, '0);
    chk("rst_alu_sel", W'(alu_sel), W'(0));
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort the P+Q program with reset while waiting on its fourth field op
    @(negedge clk);
    apply_inputs(vecs[1]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; ps = 0;
    for (k = 0; k < 2000; k++) begin
      if (alu_start && !ps) n++;
      ps = alu_start;
      if (n == 4) break;
      @(negedge clk);
    end
    chk("abort_reached_op4", W'(n), W'(4));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_alu_start", W'(alu_start), W'(0));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_rx_cleared", rx, '0);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy || alu_start) bad = 1;
    end
    chk("abort_stays_idle", W'(bad), W'(0));

    run_vec(vecs[1], "rerun_after_abort");

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
